// File: rtl/sqad_sequencer_pkg.sv
// Shared ECC definitions: field width, field-op command encodings and the
// sequencer state type.
package sqad_sequencer_pkg;

   localparam int unsigned ECC_M = 163;

   localparam logic [1:0] OP_ADD   = 2'd0;
   localparam logic [1:0] OP_ADDSQ = 2'd1;
   localparam logic [1:0] OP_MSQ   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RUN,
      S_DONE
   } sqad_state_e;

endpackage

// File: rtl/sqad_sequencer.sv
// Command sequencer for the GF(2^163) square/adder unit: runs ADD, ADDSQ or
// k chained squarings through the externally instantiated unit.
module sqad_sequencer
   import sqad_sequencer_pkg::*;
#(
   parameter int unsigned M  = ECC_M,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [CW-1:0] cmd_cnt,
   input  logic [M-1:0]  cmd_a,
   input  logic [M-1:0]  cmd_b,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [M-1:0]  res_data,
   output logic          busy,
   output logic [M-1:0]  sa_a,
   output logic [M-1:0]  sa_b,
   output logic          sa_opt,
   input  logic [M-1:0]  sa_r
);

   sqad_state_e   state_q, state_d;
   logic [M-1:0]  a_q, a_d;
   logic [M-1:0]  b_q, b_d;
   logic          opt_q, opt_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [M-1:0]  res_q, res_d;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      opt_d   = opt_q;
      rem_d   = rem_q;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               a_d     = cmd_a;
               b_d     = cmd_b;
               opt_d   = 1'b0;
               rem_d   = CW'(1);
               state_d = S_ISSUE;
               unique case (cmd_op)
                  OP_ADD:   opt_d = 1'b0;
                  OP_ADDSQ: opt_d = 1'b1;
                  OP_MSQ: begin
                     b_d   = '0;
                     opt_d = 1'b1;
                     rem_d = cmd_cnt;
                     // k == 0 is the identity; skip the unit entirely
                     if (cmd_cnt == '0) begin
                        res_d   = cmd_a;
                        state_d = S_DONE;
                     end
                  end
                  default:  opt_d = 1'b0;
               endcase
            end
         end
         S_ISSUE: state_d = S_RUN;
         S_RUN: begin
            if (rem_q == CW'(1)) begin
               res_d   = sa_r;
               state_d = S_DONE;
            end else begin
               rem_d = rem_q - CW'(1);
            end
         end
         S_DONE: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         opt_q   <= 1'b0;
         rem_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         opt_q   <= opt_d;
         rem_q   <= rem_d;
         res_q   <= res_d;
      end
   end

   // In RUN the unit's own output is fed back with B = 0 to chain squarings.
   assign sa_a      = (state_q == S_RUN) ? sa_r : a_q;
   assign sa_b      = (state_q == S_RUN) ? '0 : b_q;
   assign sa_opt    = opt_q && ((state_q == S_ISSUE) || (state_q == S_RUN));
   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign res_valid = (state_q == S_DONE);
   assign res_data  = res_q;

endmodule

// File: tb/tb_sqad_sequencer.sv
// Directed bench for sqad_sequencer with a behavioural square/adder unit
// (inputs registered, reduction by x^163 + x^7 + x^6 + x^3 + 1).
module tb_sqad_sequencer;
   import sqad_sequencer_pkg::*;

   localparam int unsigned M  = ECC_M;
   localparam int unsigned CW = 8;

   typedef struct {
      logic [M-1:0] res;
      int           lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [CW-1:0] cmd_cnt = '0;
   logic [M-1:0]  cmd_a = '0;
   logic [M-1:0]  cmd_b = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [M-1:0]  res_data;
   logic          busy;
   logic [M-1:0]  sa_a, sa_b, sa_r;
   logic          sa_opt;

   logic [M-1:0]  ua, ub;
   logic          uopt;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   sqad_sequencer #(.M(M), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_cnt(cmd_cnt), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .sa_a(sa_a), .sa_b(sa_b), .sa_opt(sa_opt), .sa_r(sa_r)
   );

   function automatic logic [M-1:0] gf_sq(input logic [M-1:0] x);
      logic [2*M-2:0] t;
      t = '0;
      for (int i = 0; i < M; i++) t[2*i] = x[i];
      for (int i = 2*M-2; i >= M; i--) begin
         if (t[i]) begin
            t[i]       = 1'b0;
            t[i-M+7]   = ~t[i-M+7];
            t[i-M+6]   = ~t[i-M+6];
            t[i-M+3]   = ~t[i-M+3];
            t[i-M]     = ~t[i-M];
         end
      end
      return t[M-1:0];
   endfunction

   // Unit model: no reset, registers its inputs.
   always_ff @(posedge clk) begin
      ua   <= sa_a;
      ub   <= sa_b;
      uopt <= sa_opt;
   end
   assign sa_r = uopt ? gf_sq(ua ^ ub) : (ua ^ ub);

   task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [M-1:0] rand_fe();
      logic [191:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return w[M-1:0];
   endfunction

   // Issues one command, then waits for res_valid and scores result/latency.
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [CW-1:0] cnt,
                          input logic [M-1:0] a, input logic [M-1:0] b,
                          input logic [M-1:0] exp_res, input int exp_lat, input logic exp_opt);
      int   cyc;
      exp_t e;
      cmd_op = op; cmd_cnt = cnt; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      check({tag, ".cmd_ready"}, M'(cmd_ready), M'(1));
      sb_q.push_back('{res: exp_res, lat: exp_lat});
      tick();
      cmd_valid = 1'b0;
      cyc = 1;
      while (!res_valid && cyc < exp_lat + 20) begin
         check({tag, ".sa_opt_run"}, M'(sa_opt), M'(exp_opt));
         check({tag, ".busy"}, M'(busy), M'(1));
         tick();
         cyc++;
      end
      e = sb_q.pop_front();
      check({tag, ".res_valid"}, M'(res_valid), M'(1));
      check({tag, ".latency"}, M'(cyc), M'(e.lat));
      check({tag, ".res_data"}, res_data, e.res);
      check({tag, ".sa_opt_done"}, M'(sa_opt), M'(0));
   endtask

   task automatic drain(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, ".ready_after"}, M'(cmd_ready), M'(1));
      check({tag, ".valid_after"}, M'(res_valid), M'(0));
   endtask

   initial begin
      logic [M-1:0] ra, rb, held;
      int cyc;

      #2;
      check("rst.cmd_ready", M'(cmd_ready), M'(1));
      check("rst.busy", M'(busy), M'(0));
      check("rst.res_valid", M'(res_valid), M'(0));
      check("rst.res_data", res_data, '0);
      check("rst.sa_opt", M'(sa_opt), M'(0));
      check("rst.sa_a", sa_a, '0);
      check("rst.sa_b", sa_b, '0);
      tick();
      rst_n = 1'b1;
      tick();

      run_cmd("add", OP_ADD, 8'd0, M'(5), M'(3), M'(6), 3, 1'b0);
      drain("add");
      run_cmd("addsq", OP_ADDSQ, 8'd0, M'(3), M'(1), M'(4), 3, 1'b1);
      drain("addsq");
      run_cmd("msq3", OP_MSQ, 8'd3, M'(2), '1, M'(256), 5, 1'b1);
      drain("msq3");
      ra = rand_fe();
      run_cmd("msq163", OP_MSQ, 8'd163, ra, '0, ra, 165, 1'b1);
      drain("msq163");
      run_cmd("msq0", OP_MSQ, 8'd0, M'(12'hABC), '0, M'(12'hABC), 1, 1'b1);
      drain("msq0");
      run_cmd("rsvd", 2'd3, 8'd9, M'(5), M'(3), M'(6), 3, 1'b0);
      drain("rsvd");
      ra = rand_fe();
      rb = rand_fe();
      run_cmd("addsq_rand", OP_ADDSQ, 8'd0, ra, rb, gf_sq(ra ^ rb), 3, 1'b1);
      drain("addsq_rand");
      ra = rand_fe();
      run_cmd("msq2_rand", OP_MSQ, 8'd2, ra, rb, gf_sq(gf_sq(ra)), 4, 1'b1);

      // Back-pressure with a competing command pending.
      held = res_data;
      cmd_op = OP_ADD; cmd_a = M'(7); cmd_b = M'(1); cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp.res_valid", M'(res_valid), M'(1));
         check("bp.res_data", res_data, held);
         check("bp.cmd_ready", M'(cmd_ready), M'(0));
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      cmd_valid = 1'b0;
      check("bp.ready_after", M'(cmd_ready), M'(1));
      check("bp.not_accepted", M'(busy), M'(0));

      // Reset in cycle 10 of an MSQ k=40.
      cmd_op = OP_MSQ; cmd_cnt = 8'd40; cmd_a = rand_fe(); cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cyc = 1;
      while (cyc < 10) begin
         tick();
         cyc++;
      end
      check("abort.busy_before", M'(busy), M'(1));
      rst_n = 1'b0;
      #1;
      check("abort.cmd_ready", M'(cmd_ready), M'(1));
      check("abort.busy", M'(busy), M'(0));
      check("abort.res_valid", M'(res_valid), M'(0));
      check("abort.res_data", res_data, '0);
      check("abort.sa_opt", M'(sa_opt), M'(0));
      check("abort.sa_a", sa_a, '0);
      check("abort.sa_b", sa_b, '0);
      tick();
      rst_n = 1'b1;
      tick();
      run_cmd("post_rst", OP_ADD, 8'd0, M'(1), M'(1), M'(0), 3, 1'b0);
      drain("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
